rap_vlsa_ctrl: RTL
==================

Name: rap_vlsa_ctrl

Overview:
- Speculative variable-latency adder controller around the windowed approximate carry-lookahead adder (the rap family).
- Accepts one operand pair per transaction and evaluates the windowed approximate sum in one cycle.
- Detects whether the truncated carry window caused an error.
- In exact mode it repairs the result with a two-cycle split exact addition. In approximate mode it returns the approximate sum tagged with the error flag.
- Keeps saturating operation and error counters for accuracy profiling.

Parameters:
- WIDTH, 16, operand width (even).
- WIN, 8, carry window: the carry out of bit i sees only bits max(0,i-WIN)..i.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_mode  in  1  0 = exact (correct on error), 1 = approximate (no correction).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH+1  result.
- out_err  out  1  approximate sum differed from the exact sum.
- out_fixed  out  1  result came from the correction path.
- clr_stats  in  1  synchronous clear of counters.
- op_cnt  out  16  completed output handshakes, saturating.
- err_cnt  out  16  detected errors, saturating.

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE; operand, mode, result and counter registers cleared. Reset mid-transaction abandons it and no output is produced.
- States: IDLE, SPEC, FIX_LO, FIX_HI, RESP. in_ready = (state==IDLE).
- Accept edge, in_valid & in_ready: register a, b, mode; go to SPEC.
- Approximate sum, computed combinationally on the registered operands:
  - p = a^b, g = a&b.
  - capx[i] = carry out of bit i from adding bits max(0,i-WIN)..i with carry-in 0.
  - sum[0] = p[0]; sum[i] = p[i]^capx[i-1] for 1≤i<WIDTH; sum[WIDTH] = capx[WIDTH-1].
- Error definition: err = (approximate sum != a+b), exact over WIDTH+1 bits. The detector may be any logic equivalent to this.
- SPEC edge:
  - err=0 or mode=1: load out_sum=approx, out_err=err, out_fixed=0; go to RESP.
  - err=1 and mode=0: go to FIX_LO.
  - In both cases err_cnt += err.
- FIX_LO edge: register the exact low half sum a[W/2-1:0]+b[W/2-1:0] and its carry-out.
- FIX_HI edge: combine with the exact high half (using the registered carry); load out_sum=exact, out_err=1, out_fixed=1; go to RESP.
- RESP: out_valid=1 and out_sum/out_err/out_fixed held stable until out_ready. On out_valid & out_ready: op_cnt += 1, out_valid←0, go to IDLE.
- Latency:
  - Result visible 2 edges after accept without correction, 4 edges with correction.
  - out_ready already high in RESP completes on that edge.
  - The earliest next accept is the edge after the handshake, since in_ready is asserted only in IDLE.
- Counters:
  - Stick at 0xFFFF.
  - clr_stats zeroes both and has priority over a same-cycle increment.
- in_valid while not ready: operands ignored, no side effect. Inputs other than in_valid/out_ready/clr_stats are sampled only at accept.

Test Plan:
1. Reset with rst_n=0 mid-FIX_LO → out_valid=0, in_ready=1, counters 0; after release, a fresh transaction completes normally.
2. a=0x1234, b=0x4321, mode=0 → out_sum=0x05555, err=0, fixed=0, out_valid 2 edges after accept; op_cnt=1, err_cnt=0.
3. a=0xFFFF, b=0x0001, mode=1 → out_sum=0x0FC00, out_err=1, out_fixed=0; err_cnt=1.
4. a=0xFFFF, b=0x0001, mode=0 → out_sum=0x10000, out_err=1, out_fixed=1, out_valid 4 edges after accept.
5. out_ready held low 5 cycles in RESP → out_sum stable, in_ready=0, extra in_valid pulses ignored; release → a single handshake, op_cnt increments once.
6. Preload err_cnt to 0xFFFF via 65535 error ops (or force) then another error → stays 0xFFFF; clr_stats coincident with an increment → 0.

Source files
------------

// File: rtl/rap_vlsa_ctrl.sv
// Speculative variable-latency adder controller: windowed approximate carry
// sum in one cycle, with optional two-cycle exact repair and saturating stats.
module rap_vlsa_ctrl #(
  parameter int WIDTH = 16,
  parameter int WIN   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic             out_fixed,
  input  logic             clr_stats,
  output logic [15:0]      op_cnt,
  output logic [15:0]      err_cnt
);

  localparam int H = WIDTH / 2;

  typedef enum logic [2:0] {IDLE, SPEC, FIX_LO, FIX_HI, RESP} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [H-1:0]     lo_sum_q;
  logic             lo_c_q;
  logic [WIDTH:0]   sum_q;
  logic             err_q, fixed_q;
  logic [15:0]      op_cnt_q, err_cnt_q;

  // Carry out of each bit, seeing only the WIN bits below it plus itself.
  function automatic logic [WIDTH-1:0] window_carry(input logic [WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] capx;
    logic             c;
    capx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = 1'b0;
      for (int j = 0; j < WIDTH; j++)
        if (j >= i - WIN && j <= i) c = g[j] | (p[j] & c);
      capx[i] = c;
    end
    return capx;
  endfunction

  logic [WIDTH-1:0] p, g, capx;
  logic [WIDTH:0]   approx, exact;
  logic             err;
  logic [H:0]       lo_full, hi_full;

  always_comb begin
    p       = a_q ^ b_q;
    g       = a_q & b_q;
    capx    = window_carry(p, g);
    approx  = {capx[WIDTH-1], p ^ {capx[WIDTH-2:0], 1'b0}};
    exact   = {1'b0, a_q} + {1'b0, b_q};
    err     = (approx != exact);
    lo_full = {1'b0, a_q[H-1:0]} + {1'b0, b_q[H-1:0]};
    hi_full = {1'b0, a_q[WIDTH-1:H]} + {1'b0, b_q[WIDTH-1:H]} + {{H{1'b0}}, lo_c_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state is defaulted to the current state first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SPEC;
      SPEC:    state_nxt = (err && !mode_q) ? FIX_LO : RESP;
      FIX_LO:  state_nxt = FIX_HI;
      FIX_HI:  state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      lo_sum_q <= '0;
      lo_c_q   <= 1'b0;
      sum_q    <= '0;
      err_q    <= 1'b0;
      fixed_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q    <= in_a;
          b_q    <= in_b;
          mode_q <= in_mode;
        end
        SPEC: if (!err || mode_q) begin
          sum_q   <= approx;
          err_q   <= err;
          fixed_q <= 1'b0;
        end
        FIX_LO: {lo_c_q, lo_sum_q} <= lo_full;
        FIX_HI: begin
          sum_q   <= {hi_full, lo_sum_q};
          err_q   <= 1'b1;
          fixed_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating counters; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (clr_stats) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (state == RESP && out_ready && op_cnt_q != 16'hFFFF)
        op_cnt_q <= op_cnt_q + 16'd1;
      if (state == SPEC && err && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign out_sum   = sum_q;
  assign out_err   = err_q;
  assign out_fixed = fixed_q;
  assign op_cnt    = op_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
